// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller: steps the 4x4 sprite every FRAME_DIV frames,
// bounces it off the screen edges and accepts host teleport/direction commands.
module sprite_motion_ctrl #(
  parameter int XMAX      = 156,
  parameter int YMAX      = 116,
  parameter int X_INIT    = 78,
  parameter int Y_INIT    = 58,
  parameter int FRAME_DIV = 2
) (
  input  logic       VGA_CLK,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic       pause,
  input  logic [1:0] speed,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic       cmd_dx,
  input  logic       cmd_dy,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       hit
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic [7:0]    XMAX_L   = 8'(XMAX);
  localparam logic [6:0]    YMAX_L   = 7'(YMAX);
  localparam logic [7:0]    XINIT_L  = 8'(X_INIT);
  localparam logic [6:0]    YINIT_L  = 7'(Y_INIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_MOVE_X = 3'd2,
    S_MOVE_Y = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic            r_dir_x;
  logic            r_dir_y;
  logic            r_hit;
  // Working copies updated during MOVE_X/MOVE_Y; outputs only follow at COMMIT.
  logic [7:0]      r_wx;
  logic [6:0]      r_wy;
  logic            r_wdx;
  logic            r_wdy;
  logic            r_bounce;
  logic [1:0]      r_speed;

  logic            w_accept;
  logic            w_frame_tick;
  logic [7:0]      w_cmd_x;
  logic [6:0]      w_cmd_y;
  logic signed [8:0] w_nx;
  logic signed [8:0] w_ny;

  assign cmd_ready    = (r_state == S_IDLE) || (r_state == S_WAIT);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_frame_tick = (r_state == S_WAIT) && !w_accept && !pause && frame_start;
  assign w_cmd_x      = (cmd_x > XMAX_L) ? XMAX_L : cmd_x;
  assign w_cmd_y      = (cmd_y > YMAX_L) ? YMAX_L : cmd_y;

  // MOVE_X uses the live speed; MOVE_Y uses the copy latched in MOVE_X.
  assign w_nx = r_wdx ? $signed({1'b0, r_wx} - {7'd0, speed})
                      : $signed({1'b0, r_wx} + {7'd0, speed});
  assign w_ny = r_wdy ? $signed({2'b00, r_wy} - {7'd0, r_speed})
                      : $signed({2'b00, r_wy} + {7'd0, r_speed});

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_accept && !pause) w_state_next = S_WAIT;
      S_WAIT: begin
        if (!w_accept) begin
          if (pause)
            w_state_next = S_IDLE;
          else if (frame_start && (r_cnt == CNT_LAST))
            w_state_next = S_MOVE_X;
        end
      end
      S_MOVE_X: w_state_next = S_MOVE_Y;
      S_MOVE_Y: w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_WAIT;
      default:  w_state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_frame_tick)
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      r_x      <= XINIT_L;
      r_y      <= YINIT_L;
      r_dir_x  <= 1'b0;
      r_dir_y  <= 1'b0;
      r_hit    <= 1'b0;
      r_wx     <= XINIT_L;
      r_wy     <= YINIT_L;
      r_wdx    <= 1'b0;
      r_wdy    <= 1'b0;
      r_bounce <= 1'b0;
      r_speed  <= 2'd0;
    end else begin
      r_hit <= 1'b0;
      if (w_accept) begin
        r_x     <= w_cmd_x;
        r_y     <= w_cmd_y;
        r_dir_x <= cmd_dx;
        r_dir_y <= cmd_dy;
        r_wx    <= w_cmd_x;
        r_wy    <= w_cmd_y;
        r_wdx   <= cmd_dx;
        r_wdy   <= cmd_dy;
      end
      case (r_state)
        S_MOVE_X: begin
          r_speed <= speed;
          if (w_nx > XMAX) begin
            r_wx     <= XMAX_L;
            r_wdx    <= ~r_wdx;
            r_bounce <= 1'b1;
          end else if (w_nx < 0) begin
            r_wx     <= 8'd0;
            r_wdx    <= ~r_wdx;
            r_bounce <= 1'b1;
          end else begin
            r_wx <= w_nx[7:0];
          end
        end
        S_MOVE_Y: begin
          if (w_ny > YMAX) begin
            r_wy     <= YMAX_L;
            r_wdy    <= ~r_wdy;
            r_bounce <= 1'b1;
          end else if (w_ny < 0) begin
            r_wy     <= 7'd0;
            r_wdy    <= ~r_wdy;
            r_bounce <= 1'b1;
          end else begin
            r_wy <= w_ny[6:0];
          end
        end
        S_COMMIT: begin
          r_x      <= r_wx;
          r_y      <= r_wy;
          r_dir_x  <= r_wdx;
          r_dir_y  <= r_wdy;
          r_hit    <= r_bounce;
          r_bounce <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign x     = r_x;
  assign y     = r_y;
  assign dir_x = r_dir_x;
  assign dir_y = r_dir_y;
  assign hit   = r_hit;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: stepping, bouncing, teleport clamping,
// handshake blocking, pause phase hold and mid-sequence reset.
module tb_sprite_motion_ctrl;

  logic       VGA_CLK = 1'b0;
  logic       resetn;
  logic       frame_start;
  logic       pause;
  logic [1:0] speed;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic       cmd_dx;
  logic       cmd_dy;
  logic [7:0] x;
  logic [6:0] y;
  logic       dir_x;
  logic       dir_y;
  logic       hit;

  int total = 0;
  int bad   = 0;

  sprite_motion_ctrl dut (
    .VGA_CLK     (VGA_CLK),
    .resetn      (resetn),
    .frame_start (frame_start),
    .pause       (pause),
    .speed       (speed),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_dx      (cmd_dx),
    .cmd_dy      (cmd_dy),
    .x           (x),
    .y           (y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .hit         (hit)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_out(input string tag, input int ex, input int ey,
                           input int edx, input int edy, input int ehit);
    check({tag, ".x"},     int'(x),     ex);
    check({tag, ".y"},     int'(y),     ey);
    check({tag, ".dir_x"}, int'(dir_x), edx);
    check({tag, ".dir_y"}, int'(dir_y), edy);
    check({tag, ".hit"},   int'(hit),   ehit);
  endtask

  // Expects frame counter at 0; returns right after the commit edge.
  task automatic step_seq(input string tag, input int old_x, input int old_y);
    frame_pulse();
    tick();
    tick();
    check({tag, ".hold_x"}, int'(x), old_x);
    frame_pulse();
    tick();
    tick();
    check({tag, ".stable_x"}, int'(x), old_x);
    check({tag, ".stable_y"}, int'(y), old_y);
    tick();
  endtask

  task automatic send_cmd(input int cx, input int cy, input int cdx, input int cdy);
    cmd_valid = 1'b1;
    cmd_x = 8'(cx);
    cmd_y = 7'(cy);
    cmd_dx = 1'(cdx);
    cmd_dy = 1'(cdy);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    frame_start = 1'b0;
    pause = 1'b0;
    speed = 2'd1;
    cmd_valid = 1'b0;
    cmd_x = '0;
    cmd_y = '0;
    cmd_dx = 1'b0;
    cmd_dy = 1'b0;
    tick();
    check_out("reset", 78, 58, 0, 0, 0);
    check("reset.ready", int'(cmd_ready), 1);
    resetn = 1'b1;
    tick();

    // basic step at speed 1
    step_seq("t1", 78, 58);
    check_out("t1.step", 79, 59, 0, 0, 0);

    // teleport then bounce at right edge
    send_cmd(155, 50, 0, 0);
    check_out("t2.tp", 155, 50, 0, 0, 0);
    speed = 2'd2;
    step_seq("t2a", 155, 50);
    check_out("t2.bounce", 156, 52, 1, 0, 1);
    tick();
    check("t2.hit_clear", int'(hit), 0);
    step_seq("t2b", 156, 52);
    check_out("t2.back", 154, 54, 1, 0, 0);

    // bounce at left edge, then clamped teleport
    send_cmd(1, 10, 1, 0);
    speed = 2'd3;
    step_seq("t3", 1, 10);
    check_out("t3.bounce", 0, 13, 0, 0, 1);
    send_cmd(200, 127, 0, 0);
    check_out("t3.clamp", 156, 116, 0, 0, 0);

    // command blocked during the update sequence
    speed = 2'd1;
    frame_pulse();
    cmd_x = 8'd20; cmd_y = 7'd20; cmd_dx = 1'b0; cmd_dy = 1'b0;
    frame_pulse();
    cmd_valid = 1'b1;
    check("t4.ready_mx", int'(cmd_ready), 0);
    tick();
    check("t4.ready_my", int'(cmd_ready), 0);
    tick();
    check("t4.ready_cm", int'(cmd_ready), 0);
    tick();
    check_out("t4.corner", 156, 116, 1, 1, 1);
    check("t4.ready_wait", int'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check_out("t4.accept", 20, 20, 0, 0, 0);

    // command coincident with frame_start keeps counter at 1
    frame_pulse();
    frame_start = 1'b1;
    send_cmd(30, 40, 0, 0);
    frame_start = 1'b0;
    check_out("t4.coinc", 30, 40, 0, 0, 0);
    frame_pulse();
    tick();
    tick();
    check("t4.coinc_stable", int'(x), 30);
    tick();
    check_out("t4.phase", 31, 41, 0, 0, 0);

    // pause holds position and frame phase
    frame_pulse();
    pause = 1'b1;
    tick();
    check("t5.ready_idle", int'(cmd_ready), 1);
    for (int i = 0; i < 5; i++) begin
      frame_pulse();
      tick();
    end
    tick(); tick();
    check_out("t5.frozen", 31, 41, 0, 0, 0);
    pause = 1'b0;
    tick();
    frame_pulse();
    tick();
    tick();
    tick();
    check_out("t5.resume", 32, 42, 0, 0, 0);

    // speed 0 still commits, no hit
    speed = 2'd0;
    step_seq("t5z", 32, 42);
    check_out("t5.speed0", 32, 42, 0, 0, 0);

    // reset during MOVE_Y
    speed = 2'd1;
    frame_pulse();
    frame_pulse();
    tick();
    resetn = 1'b0;
    #1;
    check_out("t6.reset", 78, 58, 0, 0, 0);
    check("t6.ready", int'(cmd_ready), 1);
    #2;
    resetn = 1'b1;
    tick();
    tick();
    check_out("t6.no_commit", 78, 58, 0, 0, 0);
    step_seq("t6s", 78, 58);
    check_out("t6.step", 79, 59, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame position controller for the 4x4 sprite overlaid on the 160x120 background grid. It drives the sprite's top-left x/y into the sprite/background compositor. It moves the sprite once every FRAME_DIV frames at a selectable speed and bounces it off the screen edges. Host commands over a valid/ready handshake can teleport the sprite and set its direction. Positions change only between frames, so a scanned frame never shows a torn sprite.

Parameters:
XMAX, 156, largest legal x (160 - sprite width 4)
YMAX, 116, largest legal y (120 - sprite height 4)
X_INIT, 78, x after reset
Y_INIT, 58, y after reset
FRAME_DIV, 2, frames per movement step (>=1)

Ports:
VGA_CLK  in  1  pixel clock; all state on rising edge
resetn  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pause  in  1  1 = suspend motion
speed  in  2  pixels per step on each axis; 0 = stationary
cmd_valid  in  1  host command present
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
cmd_x  in  8  teleport x
cmd_y  in  7  teleport y
cmd_dx  in  1  x direction, 0 = increasing, 1 = decreasing
cmd_dy  in  1  y direction, 0 = increasing, 1 = decreasing
x  out  8  sprite x, registered
y  out  7  sprite y, registered
dir_x  out  1  current x direction
dir_y  out  1  current y direction
hit  out  1  one-cycle pulse on a commit where any axis bounced

Behaviour:
- Reset, asynchronous while resetn=0:
  - x=X_INIT, y=Y_INIT, dir_x=dir_y=0, hit=0.
  - Frame counter = 0; state = WAIT.
- States:
  - IDLE (paused).
  - WAIT (armed, waiting for frame).
  - MOVE_X, MOVE_Y, COMMIT (update sequence).
- cmd_ready = 1 only in IDLE or WAIT. It is a combinational decode of state, so it is 1 immediately after reset.
- Command handshake (cmd_valid & cmd_ready):
  - Next edge: x = min(cmd_x, XMAX), y = min(cmd_y, YMAX), dir_x = cmd_dx, dir_y = cmd_dy.
  - The update sequence's working registers are also loaded with these values.
  - State does not change.
- WAIT transitions:
  - pause=1 -> IDLE.
  - Else frame_start=1 with no handshake that cycle:
    - if frame counter == FRAME_DIV-1: counter -> 0, go to MOVE_X;
    - otherwise counter increments, stay in WAIT.
  - A handshake in the same cycle as frame_start takes priority; that frame_start is dropped and the counter is unchanged.
- IDLE: frame_start ignored, counter held. Leaves for WAIT when pause=0.
- MOVE_X: speed sampled into an internal register. Working x computed as a 9-bit signed value nx = x ± speed.
  - nx > XMAX -> x = XMAX, dir_x flips, bounce flag set.
  - nx < 0 -> x = 0, dir_x flips, bounce flag set.
  - nx == XMAX or nx == 0 exactly -> no bounce, no flip; the reversal happens on the following step.
- MOVE_Y: same rule on the y axis against YMAX, using the sampled speed.
- COMMIT:
  - Working x/y/dir registers copied to the outputs.
  - hit = bounce flag for exactly one cycle; flag then cleared.
  - Next state: WAIT.
- Latency: outputs change on the 3rd rising edge after the edge that samples frame_start (MOVE_X, MOVE_Y, COMMIT edges).
- Outputs are stable outside COMMIT.
- pause or frame_start arriving mid-sequence is ignored until WAIT; the sequence always completes.
- speed=0: the sequence still runs and commits unchanged values; hit=0.
- resetn asserted mid-sequence aborts immediately to reset values; no partial commit.

Test Plan:
1. Reset, FRAME_DIV=2, speed=1, one frame_start pulse -> x=78, y=58 unchanged, no hit. Second pulse -> x=79, y=59 three cycles later; hit=0.
2. Teleport cmd x=155, y=50, dx=0, dy=0 in WAIT -> next edge x=155, y=50. Step at speed=2 -> x=156, dir_x=1, hit=1 for one cycle. Next step -> x=154.
3. Teleport x=1, dx=1, speed=3 -> step gives x=0, dir_x=0, hit=1. Teleport x=200, y=127 -> clamped x=156, y=116.
4. cmd_valid held through an update sequence -> cmd_ready=0 in MOVE_X, MOVE_Y and COMMIT; command accepted on the first WAIT cycle. Command coincident with frame_start -> command applied, frame counter unchanged.
5. pause=1 while in WAIT, with 5 frame_start pulses -> x/y frozen and counter held. pause=0 -> motion resumes on the correct frame phase.
6. resetn pulsed low during MOVE_Y -> x=78, y=58, hit=0 immediately, state WAIT, cmd_ready=1.
